// File: rtl/i2c_sample_slave.sv
// Write-only I2C target: receives an address byte plus 8-bit samples, ACKs when addressed,
// and strobes each sample out. Optional input glitch filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_sample_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h4D,
   parameter int         FILTER_LEN = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        rw_bit,
   output logic        addr_match,
   output logic        busy,
   output logic [15:0] rx_count
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE} state_t;

   logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0] line;

   always_comb begin
      sync1_d = {scl_in, sda_in};
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

   // Bit 1 is SCL, bit 0 is SDA; each line only follows its input after FILTER_LEN steady cycles.
   for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_q, filt_d;

      always_comb begin
         cnt_d  = '0;
         filt_d = filt_q;
         if (sync2_q[gi] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync2_q[gi];
            else                              cnt_d  = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
         end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
         end
      end

      assign line[gi] = filt_q;
   end
`else
   assign line = sync2_q;
`endif

   logic scl_prev_q, sda_prev_q;
   logic scl_rise, scl_fall, start_det, stop_det;

   // START/STOP require SCL steady high across both samples, so a simultaneous change is data.
   assign scl_rise  = line[1] & ~scl_prev_q;
   assign scl_fall  = ~line[1] & scl_prev_q;
   assign start_det = scl_prev_q & line[1] & sda_prev_q & ~line[0];
   assign stop_det  = scl_prev_q & line[1] & ~sda_prev_q & line[0];

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        sda_oe_q, sda_oe_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        data_valid_q, data_valid_d;
   logic        rw_bit_q, rw_bit_d;
   logic        addr_match_q, addr_match_d;
   logic        busy_q, busy_d;
   logic [15:0] rx_count_q, rx_count_d;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      sda_oe_d     = sda_oe_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      rw_bit_d     = rw_bit_q;
      addr_match_d = addr_match_q;
      busy_d       = busy_q;
      rx_count_d   = rx_count_q;

      if (start_det) begin
         busy_d       = 1'b1;
         addr_match_d = 1'b0;
         sda_oe_d     = 1'b0;
         bit_cnt_d    = 4'd0;
         state_d      = S_ADDR;
      end else if (stop_det) begin
         busy_d       = 1'b0;
         addr_match_d = 1'b0;
         sda_oe_d     = 1'b0;
         bit_cnt_d    = 4'd0;
         state_d      = S_IDLE;
      end else begin
         unique case (state_q)
            S_ADDR, S_DATA: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], line[0]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == S_DATA) begin
                        data_out_d   = shreg_d;
                        data_valid_d = 1'b1;
                        if (rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 16'd1;
                        state_d = S_DATA_ACK;
                     end else if (shreg_d[7:1] == SLAVE_ADDR) begin
                        rw_bit_d     = shreg_d[0];
                        addr_match_d = 1'b1;
                        state_d      = S_ADDR_ACK;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end
            // First SCL fall after bit 8 starts driving ACK; the next fall (end of 9th clock) ends it.
            S_ADDR_ACK, S_DATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = S_DATA;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         state_q      <= S_IDLE;
         bit_cnt_q    <= 4'd0;
         shreg_q      <= 8'h00;
         sda_oe_q     <= 1'b0;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         rw_bit_q     <= 1'b0;
         addr_match_q <= 1'b0;
         busy_q       <= 1'b0;
         rx_count_q   <= 16'h0000;
      end else begin
         scl_prev_q   <= line[1];
         sda_prev_q   <= line[0];
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         sda_oe_q     <= sda_oe_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         rw_bit_q     <= rw_bit_d;
         addr_match_q <= addr_match_d;
         busy_q       <= busy_d;
         rx_count_q   <= rx_count_d;
      end
   end

   assign sda_oe     = sda_oe_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign rw_bit     = rw_bit_q;
   assign addr_match = addr_match_q;
   assign busy       = busy_q;
   assign rx_count   = rx_count_q;

endmodule
